// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit counters and branch statistics
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
module branch_predictor #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  take_branch,
  output logic [ADDR_WIDTH-1:0] branch_predict,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 1;
  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [CNT_WIDTH-1:0]  branch_count_q, mispredict_count_q;
  logic [CNT_WIDTH-1:0]  branch_count_d, mispredict_count_d;
  logic [INDEX_BITS-1:0] idx, u_idx;
  logic [TAG_W-1:0]      u_tag;
  logic                  hit, u_hit, wr_en;
  logic [1:0]            ctr_d;
  logic [ADDR_WIDTH-1:0] target_d;
  // Lookup straight from registered entries; no bypass of a same-cycle update
  always_comb begin
    idx            = pc[INDEX_BITS:1];
    hit            = valid_q[idx] && tag_q[idx] == pc[ADDR_WIDTH-1:INDEX_BITS+1];
    take_branch    = hit && ctr_q[idx][1];
    branch_predict = hit ? target_q[idx] : '0;
  end
  // Next state of the trained entry: saturating step on a hit, weakly-taken allocate on a taken miss
  always_comb begin
    u_idx              = update_pc[INDEX_BITS:1];
    u_tag              = update_pc[ADDR_WIDTH-1:INDEX_BITS+1];
    u_hit              = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    wr_en              = update_valid && (u_hit || update_taken);
    ctr_d              = !u_hit ? 2'd2
                       : update_taken ? (ctr_q[u_idx] == 2'd3 ? 2'd3 : ctr_q[u_idx] + 2'd1)
                       : (ctr_q[u_idx] == 2'd0 ? 2'd0 : ctr_q[u_idx] - 2'd1);
    target_d           = update_taken ? update_target : target_q[u_idx];
    branch_count_d     = branch_count_q + CNT_WIDTH'(update_valid);
    mispredict_count_d = mispredict_count_q + CNT_WIDTH'(update_valid && update_mispredict);
  end
  // Entry array and statistics registers; reset wins over any in-flight update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd0;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= target_d;
        ctr_q[u_idx]    <= ctr_d;
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table, directed corner sequences and randomized checks against a reference model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc, update_pc, update_target;
  logic        update_valid, update_taken, update_mispredict;
  logic        take_branch, take4;
  logic [15:0] branch_predict, pred4;
  logic [31:0] branch_count, mispredict_count;
  logic [3:0]  bc4, mc4;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_valid [16];
  int          m_tag   [16];
  int          m_tgt   [16];
  int          m_ctr   [16];
  longint      m_bc, m_mc;
  typedef struct {
    logic        v;
    logic [15:0] upc;
    logic        t;
    logic [15:0] tgt;
    logic        mp;
    logic [15:0] lpc;
    logic        exp_take;
    logic [15:0] exp_pred;
  } vec_t;
  vec_t vecs [15];

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_WIDTH(16), .INDEX_BITS(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .take_branch(take_branch), .branch_predict(branch_predict),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.ADDR_WIDTH(16), .INDEX_BITS(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .pc(pc), .take_branch(take4), .branch_predict(pred4),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .branch_count(bc4), .mispredict_count(mc4)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic m_lookup(input logic [15:0] a, output logic t, output logic [15:0] p);
    int i;
    bit h;
    i = (int'(a) / 2) % 16;
    h = m_valid[i] != 0 && m_tag[i] == int'(a) / 32;
    t = h && m_ctr[i] >= 2;
    p = h ? 16'(m_tgt[i]) : 16'd0;
  endtask

  task automatic m_update(input logic [15:0] a, input logic t, input logic [15:0] tgt, input logic mp);
    int i;
    i = (int'(a) / 2) % 16;
    m_bc++;
    if (mp) m_mc++;
    if (m_valid[i] != 0 && m_tag[i] == int'(a) / 32) begin
      if (t) begin
        m_ctr[i] = m_ctr[i] < 3 ? m_ctr[i] + 1 : 3;
        m_tgt[i] = int'(tgt);
      end else m_ctr[i] = m_ctr[i] > 0 ? m_ctr[i] - 1 : 0;
    end else if (t) begin
      m_valid[i] = 1; m_tag[i] = int'(a) / 32; m_tgt[i] = int'(tgt); m_ctr[i] = 2;
    end
  endtask

  task automatic check_counts();
    check("branch_count", branch_count, 32'(m_bc));
    check("mispredict_count", mispredict_count, 32'(m_mc));
    check("branch_count_w4", 32'(bc4), 32'(m_bc % 16));
    check("mispredict_count_w4", 32'(mc4), 32'(m_mc % 16));
  endtask

  // one cycle starting at negedge: lookup checked before the edge, counters after it
  task automatic cycle(input logic v, input logic [15:0] upc, input logic t, input logic [15:0] tgt,
                       input logic mp, input logic [15:0] lpc);
    logic et;
    logic [15:0] ep;
    update_valid = v; update_pc = upc; update_taken = t; update_target = tgt;
    update_mispredict = mp; pc = lpc;
    #1;
    m_lookup(lpc, et, ep);
    check("take_branch", 32'(take_branch), 32'(et));
    check("branch_predict", 32'(branch_predict), 32'(ep));
    check("take_branch_w4", 32'(take4), 32'(et));
    @(posedge clk);
    if (v) m_update(upc, t, tgt, mp);
    @(negedge clk);
    update_valid = 1'b0;
    check_counts();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0040, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 16'h0100};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0100};
    vecs[4]  = '{1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0100};
    vecs[5]  = '{1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0100};
    vecs[6]  = '{1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0100};
    vecs[7]  = '{1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0100};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0100};
    vecs[9]  = '{1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0100};
    vecs[10] = '{1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0100};
    vecs[11] = '{1'b1, 16'h0040, 1'b1, 16'h0200, 1'b1, 16'h0040, 1'b0, 16'h0100};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0200};
    vecs[13] = '{1'b1, 16'h0022, 1'b0, 16'h0000, 1'b0, 16'h0022, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0022, 1'b0, 16'h0000};
    reset = 1'b0; pc = '0; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset_take", 32'(take_branch), 32'd0);
    check("reset_count", branch_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      update_valid = vecs[k].v; update_pc = vecs[k].upc; update_taken = vecs[k].t;
      update_target = vecs[k].tgt; update_mispredict = vecs[k].mp; pc = vecs[k].lpc;
      #1;
      check($sformatf("vec%0d_take", k), 32'(take_branch), 32'(vecs[k].exp_take));
      check($sformatf("vec%0d_pred", k), 32'(branch_predict), 32'(vecs[k].exp_pred));
      @(posedge clk);
      if (vecs[k].v) m_update(vecs[k].upc, vecs[k].t, vecs[k].tgt, vecs[k].mp);
      @(negedge clk);
      update_valid = 1'b0;
    end
    check("stats_branch10", branch_count, 32'd10);
    check("stats_mispredict3", mispredict_count, 32'd3);
    for (int k = 0; k < 7; k++) cycle(1'b1, 16'h0006, 1'b0, 16'h0000, 1'b0, 16'h0006);
    check("wrap_w4_branch", 32'(bc4), 32'd1);
    check("branch17", branch_count, 32'd17);
    // asynchronous reset mid-run with an update in flight
    update_valid = 1'b1; update_pc = 16'h0080; update_taken = 1'b1; update_target = 16'h0300;
    pc = 16'h0040;
    #2 reset = 1'b0;
    #1;
    check("async_reset_take", 32'(take_branch), 32'd0);
    check("async_reset_pred", 32'(branch_predict), 32'd0);
    check("async_reset_bc", branch_count, 32'd0);
    check("async_reset_mc", mispredict_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    update_valid = 1'b0;
    reset = 1'b1;
    m_reset();
    pc = 16'h0080;
    #1;
    check("lost_update_take", 32'(take_branch), 32'd0);
    check("lost_update_pred", 32'(branch_predict), 32'd0);
    check_counts();
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      logic [15:0] a, b;
      a = 16'($urandom_range(0, 127));
      b = $urandom_range(0, 1) != 0 ? a : 16'($urandom_range(0, 127));
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom), 16'($urandom), 1'($urandom), b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It supplies `take_branch` and `branch_predict` to the program counter for the current fetch `pc`. It is trained by branch resolutions from the execute stage, which is the same stage that raises `flush` on a mispredict. It also keeps running counts of resolved branches and mispredicts for performance reporting.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (16): instruction address width.
- `INDEX_BITS`, default 4: log2 of entry count. 16 entries by default.
- `CNT_WIDTH`, default 32: width of the statistics counters.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately while low.
- `pc`  input  ADDR_WIDTH  current fetch address.
- `take_branch`  output  1  predict taken for `pc`.
- `branch_predict`  output  ADDR_WIDTH  predicted target for `pc`.
- `update_valid`  input  1  one resolved conditional branch this cycle.
- `update_pc`  input  ADDR_WIDTH  address of the resolved branch.
- `update_taken`  input  1  actual outcome.
- `update_target`  input  ADDR_WIDTH  actual target; only meaningful when taken.
- `update_mispredict`  input  1  execute stage flushed for this branch.
- `branch_count`  output  CNT_WIDTH  resolved branches since reset.
- `mispredict_count`  output  CNT_WIDTH  mispredicts since reset.

## Operation
- Address split:
  - index = `pc[INDEX_BITS:1]`; bit 0 is ignored because instructions are 2-byte aligned.
  - tag = `pc[ADDR_WIDTH-1:INDEX_BITS+1]`.
- Entry fields: `valid`, `tag`, `target[ADDR_WIDTH-1:0]`, `ctr[1:0]`.
- Lookup is combinational from registered entry state:
  - hit = `valid` && tag match.
  - `take_branch` = hit && `ctr[1]`.
  - `branch_predict` = entry `target` on a hit, otherwise 0.
  - The predictor does not gate on opcode; the program counter does.
- Update, applied on posedge when `update_valid`=1, at the entry indexed by `update_pc`:
  - Hit and taken: `ctr` increments, saturating at 3; `target` <= `update_target`.
  - Hit and not taken: `ctr` decrements, saturating at 0; `target` is unchanged; the entry stays valid.
  - Miss and taken: allocate and overwrite any prior occupant. Set `valid`=1, tag from `update_pc`, `target`=`update_target`, `ctr`=2 (weakly taken).
  - Miss and not taken: no change.
- Statistics, on `update_valid`:
  - `branch_count` += 1.
  - `mispredict_count` += `update_mispredict`.
  - Both counters wrap modulo 2^CNT_WIDTH.
  - `update_mispredict` is taken from the execute stage and is not recomputed here.
- No internal state machine. The only sequential state is the entry array and the two counters.

## Timing
- Reset (`reset`=0, asynchronous): all `valid`=0, all `ctr`=0, all tags and targets 0, both counters 0.
  - Consequence: `take_branch`=0 and `branch_predict`=0 during and after reset until the first allocation.
- Reset has priority over any update in the same cycle. An update in flight when reset asserts is lost.
- Lookup latency is 0 cycles: outputs follow `pc` within the same cycle.
- An update is visible to lookups from the cycle after its posedge.
- Same-cycle lookup and update to the same index: lookup returns pre-update state. There is no bypass.
- `update_valid` is a single-cycle strobe with at most one update per cycle. Back-to-back updates to the same entry apply cumulatively, one step each.
- Stall and flush are not inputs. Prediction continues during a stall, and the program counter ignores it.

## Test plan
- Reset behaviour: hold `reset`=0 mid-run after several allocations, then release; lookup of `pc`=0x0040 -> `take_branch`=0, `branch_predict`=0, both counters 0.
- Allocate: update `pc`=0x0040, taken, target 0x0100; next cycle lookup 0x0040 -> `take_branch`=1, `branch_predict`=0x0100. Lookup 0x0000 (same index, different tag) -> `take_branch`=0.
- Counter saturation: after allocation, apply 3 taken updates -> `ctr` holds 3. Then 2 not-taken updates -> `take_branch`=0; 2 further not-taken -> `ctr` holds 0. One taken -> `ctr`=1, still `take_branch`=0.
- Not-taken miss: update `pc`=0x0022, not taken, on an empty entry -> entry stays invalid and `branch_count` increments.
- Same-cycle hazard: lookup and allocate 0x0040 in the same cycle -> old (miss) result that cycle, hit the next cycle.
- Statistics: 10 updates, 3 with `update_mispredict`=1 -> `branch_count`=10, `mispredict_count`=3. Preload `CNT_WIDTH`=4 and run 17 updates -> `branch_count`=1.
